// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned IFU_PC_W    = 16;
    localparam int unsigned IFU_INSTR_W = 16;
    localparam int unsigned INSTR_BYTES = 2;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalted
    } ifu_state_t;

    typedef struct packed {
        logic [IFU_PC_W-1:0]    pc;
        logic [IFU_INSTR_W-1:0] instr;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO with flush and a registered head entry. The head register keeps its last
// value when the FIFO drains, so the consumer never sees X after reset.
module ifu_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_q, wr_q, rd_nxt;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rd_nxt  = rd_q + PtrW'(1);
    assign head_o  = head_q;

    // Next head: the following stored entry on pop, or the incoming word when it lands in an
    // empty (or emptying) FIFO; otherwise hold.
    always_comb begin
        head_d = head_q;
        if (!flush_i) begin
            if (do_pop) begin
                if (cnt_q >= CntW'(2)) begin
                    head_d = mem_q[rd_nxt];
                end else if (do_push) begin
                    head_d = wdata_i;
                end
            end else if (empty_o && do_push) begin
                head_d = wdata_i;
            end
        end
    end

    // Occupancy bookkeeping.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers, count and head register with synchronous reset and flush.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            head_q <= head_d;
            if (flush_i) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (do_push) wr_q <= wr_q + PtrW'(1);
                if (do_pop)  rd_q <= rd_nxt;
                cnt_q <= cnt_d;
            end
        end
    end

    // Storage array; contents are only read once written, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational ROM, buffers words in a small
// prefetch FIFO and hands them to decode over valid/ready. Supports redirect with flush and
// stops fetching at the end of the ROM image.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned     PC_W       = IFU_PC_W,
    parameter int unsigned     INSTR_W    = IFU_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
    parameter logic [PC_W-1:0] ROM_LIMIT  = 16'h0032,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    pc_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               halted,
    output logic               misalign
);

    localparam int unsigned EntryW = PC_W + INSTR_W;

    ifu_state_t         state_q;
    logic [PC_W-1:0]    fetch_pc_q;
    logic               halted_q;
    logic               misalign_q;
    logic               fifo_full, fifo_empty;
    logic               fetch_en;
    logic [EntryW-1:0]  head;

    // Fetch only in RUN, below the image end, with space that exists before any pop this cycle.
    assign fetch_en = (state_q == StRun) && !fifo_full && !redirect_valid &&
                      (fetch_pc_q < ROM_LIMIT);

    assign pc_o      = fetch_pc_q;
    assign out_valid = !fifo_empty;
    assign out_pc    = head[EntryW-1:INSTR_W];
    assign out_instr = head[INSTR_W-1:0];
    assign halted    = halted_q;
    assign misalign  = misalign_q;

    ifu_fifo #(
        .Width (EntryW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (redirect_valid),
        .push_i  (fetch_en),
        .wdata_i ({fetch_pc_q, instr_i}),
        .pop_i   (out_ready),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // PC register and RUN/DRAIN/HALTED sequencing; redirect overrides every state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            state_q    <= StRun;
            fetch_pc_q <= {redirect_pc[PC_W-1:1], 1'b0};
            halted_q   <= 1'b0;
            misalign_q <= redirect_pc[0];
        end else begin
            misalign_q <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (fetch_pc_q >= ROM_LIMIT) begin
                        state_q <= StDrain;
                    end else if (fetch_en) begin
                        fetch_pc_q <= fetch_pc_q + PC_W'(INSTR_BYTES);
                    end
                end
                StDrain: begin
                    if (fifo_empty) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                    end
                end
                StHalted: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

endmodule
